// File: rtl/msdf_pkg.sv
// Shared definitions for MSDF digit-serial stream scheduling.
// A token is {last, plus, minus}; plus and minus together encode one signed digit.
package msdf_pkg;

    localparam int unsigned DIGIT_W   = 3;
    localparam int unsigned LAST_BIT  = 2;
    localparam int unsigned PLUS_BIT  = 1;
    localparam int unsigned MINUS_BIT = 0;

    typedef enum logic {IDLE, LOCKED} arb_state_e;

    localparam logic [DIGIT_W-1:0] ZERO_DIGIT = 3'b000;

endpackage

// File: rtl/msdf_stream_arb_if.sv
// Elastic token channel between N_REQ producers, the arbiter and one shared MSDF operator.
interface msdf_stream_arb_if import msdf_pkg::*; #(
    parameter int unsigned N_REQ = 4
) ();

    logic [DIGIT_W*N_REQ-1:0] dataInArray;
    logic [N_REQ-1:0]         pValidArray;
    logic [N_REQ-1:0]         readyArray;
    logic [DIGIT_W-1:0]       dataOutArray_0;
    logic                     validArray_0;
    logic                     nReadyArray_0;

    modport master (
        input  dataInArray,
        input  pValidArray,
        input  nReadyArray_0,
        output readyArray,
        output dataOutArray_0,
        output validArray_0
    );

    modport slave (
        output dataInArray,
        output pValidArray,
        output nReadyArray_0,
        input  readyArray,
        input  dataOutArray_0,
        input  validArray_0
    );

endinterface

// File: rtl/msdf_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module msdf_rr_pick #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic             any,
    output logic [IDX_W-1:0] idx
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        any  = 1'b0;
        idx  = '0;
        cand = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            cand = IDX_W'((32'(ptr) + k) % N_REQ);
            if (!any && req[cand]) begin
                any = 1'b1;
                idx = cand;
            end
        end
    end

endmodule

// File: rtl/msdf_stream_arb.sv
// Stream-granular round-robin arbiter in front of a shared MSDF operator.
// Grant is held until the last-flagged token (or MAX_DIGITS tokens) has been transferred.
module msdf_stream_arb import msdf_pkg::*; #(
    parameter int unsigned N_REQ      = 4,
    parameter int unsigned MAX_DIGITS = 64,
    parameter int unsigned GID_W      = $clog2(N_REQ)
) (
    input  logic                 clk,
    input  logic                 rstn,
    msdf_stream_arb_if.master    bus,
    output logic [GID_W-1:0]     grant_id,
    output logic                 busy,
    output logic [7:0]           digit_idx,
    output logic                 overflow
);

    arb_state_e         state_q, state_d;
    logic [GID_W-1:0]   grant_q, grant_d;
    logic [GID_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [7:0]         digit_q, digit_d;
    logic               ovf_q, ovf_d;

    logic               pick_any;
    logic [GID_W-1:0]   pick_idx;
    logic [DIGIT_W-1:0] data_arr [N_REQ];
    logic [DIGIT_W-1:0] sel_data;
    logic               sel_valid;
    logic               xfer;
    logic               at_max;
    logic               rel;

    msdf_rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (GID_W)
    ) u_pick (
        .req (bus.pValidArray),
        .ptr (rr_ptr_q),
        .any (pick_any),
        .idx (pick_idx)
    );

    for (genvar g = 0; g < N_REQ; g++) begin : g_slice
        assign data_arr[g] = bus.dataInArray[DIGIT_W*g +: DIGIT_W];
    end

    assign sel_data  = data_arr[grant_q];
    assign sel_valid = bus.pValidArray[grant_q];
    assign at_max    = (digit_q == 8'(MAX_DIGITS - 1));
    assign xfer      = (state_q == LOCKED) && sel_valid && bus.nReadyArray_0;
    // Release on the last token, or force it when the stream hits the digit limit.
    assign rel       = xfer && (sel_data[LAST_BIT] || at_max);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (pick_any) state_d = LOCKED;
            LOCKED:  if (rel)      state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // rr_ptr moves only on release so a granted requester cannot be skipped mid-pick.
    always_comb begin
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        digit_d  = digit_q;
        ovf_d    = ovf_q;
        if (state_q == IDLE && pick_any) begin
            grant_d = pick_idx;
        end
        if (rel) begin
            rr_ptr_d = (grant_q == GID_W'(N_REQ - 1)) ? '0 : grant_q + GID_W'(1);
            digit_d  = '0;
            if (!sel_data[LAST_BIT]) begin
                ovf_d = 1'b1;
            end
        end else if (xfer) begin
            digit_d = digit_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            grant_q  <= '0;
            rr_ptr_q <= '0;
            digit_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
            digit_q  <= digit_d;
            ovf_q    <= ovf_d;
        end
    end

    always_comb begin
        bus.dataOutArray_0 = ZERO_DIGIT;
        bus.validArray_0   = 1'b0;
        bus.readyArray     = '0;
        if (state_q == LOCKED) begin
            bus.dataOutArray_0      = sel_data;
            bus.validArray_0        = sel_valid;
            bus.readyArray[grant_q] = bus.nReadyArray_0;
        end
    end

    assign grant_id  = grant_q;
    assign busy      = (state_q == LOCKED);
    assign digit_idx = digit_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_msdf_stream_arb.sv
// Scoreboard bench for msdf_stream_arb: directed streams are queued per requester, and the
// expected (owner, token, digit index) of every transfer is checked by a separate monitor.
module tb_msdf_stream_arb;
    import msdf_pkg::*;

    localparam int unsigned NR = 4;
    localparam int unsigned MD = 4;

    typedef logic [DIGIT_W-1:0] tok_t;
    typedef struct packed {
        logic [1:0] gid;
        tok_t       tok;
        logic [7:0] idx;
    } exp_t;

    logic       clk = 1'b0;
    logic       rstn;
    logic [1:0] grant_id;
    logic       busy;
    logic [7:0] digit_idx;
    logic       overflow;

    msdf_stream_arb_if #(.N_REQ(NR)) bus ();

    msdf_stream_arb #(
        .N_REQ      (NR),
        .MAX_DIGITS (MD)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .bus       (bus),
        .grant_id  (grant_id),
        .busy      (busy),
        .digit_idx (digit_idx),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    tok_t          src_q [NR][$];
    exp_t          exp_q [$];
    exp_t          mon_e;
    logic [NR-1:0] hold = '0;
    logic [NR-1:0] drv_fire;
    int            n_tests = 0;
    int            n_fail = 0;
    int            xfer_cnt = 0;
    int            cyc = 0;
    int            last_xfer_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    function automatic tok_t tk(input logic l, input logic p, input logic m);
        tok_t t;
        t = '0;
        t[LAST_BIT]  = l;
        t[PLUS_BIT]  = p;
        t[MINUS_BIT] = m;
        return t;
    endfunction

    task automatic drive();
        logic [NR*DIGIT_W-1:0] d;
        logic [NR-1:0]         v;
        d = '0;
        v = '0;
        for (int i = 0; i < NR; i++) begin
            if (src_q[i].size() > 0) begin
                d[DIGIT_W*i +: DIGIT_W] = src_q[i][0];
                v[i] = !hold[i];
            end
        end
        bus.dataInArray = d;
        bus.pValidArray = v;
    endtask

    task automatic add(input int r, input tok_t t, input int idx);
        src_q[r].push_back(t);
        exp_q.push_back('{gid: 2'(r), tok: t, idx: 8'(idx)});
    endtask

    task automatic wait_xfers(input int target, input int budget);
        int n = 0;
        while (xfer_cnt < target && n < budget) begin
            @(posedge clk);
            n++;
        end
        chk("xfer_wait", xfer_cnt, target);
    endtask

    // Holds reset for two edges, checks the reset values, returns at posedge+2.
    task automatic reset_and_check(input string name);
        bus.nReadyArray_0 = 1'b0;
        rstn = 1'b0;
        hold = '0;
        for (int i = 0; i < NR; i++) src_q[i].delete();
        drive();
        repeat (2) @(posedge clk);
        #2;
        rstn = 1'b1;
        bus.nReadyArray_0 = 1'b1;
        @(negedge clk);
        chk({name, "_busy"}, busy, 0);
        chk({name, "_valid"}, bus.validArray_0, 0);
        chk({name, "_ready"}, bus.readyArray, 0);
        chk({name, "_data"}, bus.dataOutArray_0, 0);
        chk({name, "_gid"}, grant_id, 0);
        chk({name, "_idx"}, digit_idx, 0);
        chk({name, "_ovf"}, overflow, 0);
        @(posedge clk);
        #2;
    endtask

    // Requester model: pop a token after each edge on which it was accepted.
    always begin
        @(negedge clk);
        drv_fire = bus.readyArray & bus.pValidArray;
        @(posedge clk);
        #1;
        for (int i = 0; i < NR; i++) begin
            if (drv_fire[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
        end
        drive();
    end

    always @(negedge clk) begin
        if (rstn && bus.validArray_0 && bus.nReadyArray_0) begin
            xfer_cnt++;
            last_xfer_cyc = cyc;
            if (exp_q.size() == 0) begin
                chk("unexpected_xfer", exp_q.size(), 1);
            end else begin
                mon_e = exp_q.pop_front();
                chk("tok", bus.dataOutArray_0, mon_e.tok);
                chk("gid", grant_id, mon_e.gid);
                chk("idx", digit_idx, mon_e.idx);
                chk("ready_onehot", bus.readyArray, 4'b1 << mon_e.gid);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int base;
        int s;
        int exp_idx;
        logic pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

        reset_and_check("por");

        // Reset in the middle of a 5-digit stream from requester 1.
        base = xfer_cnt;
        add(1, tk(0, 1, 0), 0);
        add(1, tk(0, 0, 1), 1);
        add(1, tk(0, 1, 0), 2);
        src_q[1].push_back(tk(0, 0, 1));
        src_q[1].push_back(tk(1, 1, 0));
        drive();
        wait_xfers(base + 3, 20);
        #2;
        chk("mid_idx", digit_idx, 3);
        reset_and_check("mid_rst");
        chk("mid_drain", exp_q.size(), 0);

        // Single requester, three-digit stream.
        base = xfer_cnt;
        add(2, tk(0, 1, 0), 0);
        add(2, tk(0, 0, 1), 1);
        add(2, tk(1, 1, 0), 2);
        drive();
        @(negedge clk);
        chk("single_idle_busy", busy, 0);
        @(negedge clk);
        chk("single_gid", grant_id, 2);
        chk("single_busy", busy, 1);
        chk("single_valid", bus.validArray_0, 1);
        wait_xfers(base + 3, 20);
        @(negedge clk);
        chk("single_release", busy, 0);
        chk("single_idx0", digit_idx, 0);
        chk("single_drain", exp_q.size(), 0);

        // Round robin: everyone valid, 2-digit streams, order 0,1,2,3,0.
        @(posedge clk);
        #2;
        reset_and_check("rr_rst");
        base = xfer_cnt;
        s = cyc;
        add(0, tk(0, 1, 0), 0);
        add(0, tk(1, 0, 0), 1);
        add(1, tk(0, 0, 1), 0);
        add(1, tk(1, 1, 0), 1);
        add(2, tk(0, 1, 0), 0);
        add(2, tk(1, 0, 1), 1);
        add(3, tk(0, 0, 1), 0);
        add(3, tk(1, 0, 0), 1);
        add(0, tk(0, 0, 1), 0);
        add(0, tk(1, 1, 0), 1);
        drive();
        wait_xfers(base + 10, 60);
        chk("rr_span", last_xfer_cyc - s, 14);
        chk("rr_drain", exp_q.size(), 0);

        // Backpressure on requester 1 with nReady pattern 1,0,0,1,1,1.
        #2;
        bus.nReadyArray_0 = 1'b0;
        add(1, tk(0, 0, 0), 0);
        add(1, tk(0, 1, 0), 1);
        add(1, tk(0, 0, 1), 2);
        add(1, tk(1, 1, 0), 3);
        drive();
        @(posedge clk);
        #2;
        exp_idx = 0;
        for (int k = 0; k < 6; k++) begin
            bus.nReadyArray_0 = pat[k];
            @(negedge clk);
            chk("bp_ready", bus.readyArray, pat[k] ? 4'b0010 : 4'b0000);
            chk("bp_idx", digit_idx, exp_idx);
            chk("bp_gid", grant_id, 1);
            chk("bp_busy", busy, 1);
            if (pat[k]) exp_idx++;
            @(posedge clk);
            #2;
        end
        bus.nReadyArray_0 = 1'b1;
        @(negedge clk);
        chk("bp_release", busy, 0);
        chk("bp_ovf", overflow, 0);
        chk("bp_drain", exp_q.size(), 0);

        // Overflow: six digits without a last flag, limit four.
        @(posedge clk);
        #2;
        base = xfer_cnt;
        for (int k = 0; k < 6; k++) begin
            add(0, (k % 2 == 0) ? tk(0, 1, 0) : tk(0, 0, 1), k % 4);
        end
        drive();
        @(negedge clk);
        chk("ovf_before", overflow, 0);
        wait_xfers(base + 4, 30);
        @(negedge clk);
        chk("ovf_forced_busy", busy, 0);
        chk("ovf_set", overflow, 1);
        chk("ovf_idx0", digit_idx, 0);
        wait_xfers(base + 6, 30);
        @(negedge clk);
        chk("ovf_regrant_busy", busy, 1);
        chk("ovf_regrant_gid", grant_id, 0);
        chk("ovf_regrant_idx", digit_idx, 2);
        repeat (3) @(negedge clk);
        chk("ovf_sticky", overflow, 1);
        chk("ovf_drain", exp_q.size(), 0);
        @(posedge clk);
        #2;
        reset_and_check("ovf_rst");

        // Owner withdraws valid for 5 cycles while others wait.
        base = xfer_cnt;
        add(0, tk(0, 1, 0), 0);
        add(0, tk(0, 0, 1), 1);
        add(0, tk(1, 1, 0), 2);
        add(1, tk(1, 0, 1), 0);
        add(2, tk(1, 1, 0), 0);
        drive();
        wait_xfers(base + 1, 20);
        #2;
        hold[0] = 1'b1;
        drive();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("gap_valid", bus.validArray_0, 0);
            chk("gap_gid", grant_id, 0);
            chk("gap_busy", busy, 1);
            chk("gap_idx", digit_idx, 1);
            @(posedge clk);
            #2;
        end
        hold[0] = 1'b0;
        drive();
        wait_xfers(base + 5, 40);
        chk("gap_drain", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/msdf_stream_arb.md
# msdf_stream_arb

Round-robin arbiter that shares one downstream MSDF online operator (e.g. a constant generator, adder or multiplier stage) between up to N_REQ digit-serial requesters. Each requester presents a stream of 3-bit signed-digit tokens {last, plus, minus} on an elastic valid/ready channel. Grant is held for a whole stream and released only when the token carrying the last flag is transferred. The block sits between the producing operators and the shared operator's input port in the elastic dataflow graph.

## Interface

Parameters:
- N_REQ, 4, number of requesters (2..8)
- MAX_DIGITS, 64, maximum digits per stream before forced release (2..255)

Ports:
- clk  in  1  clock
- rstn  in  1  reset, synchronous, active-low
- dataInArray  in  3*N_REQ  requester i token at [3i+2:3i]: bit2 last, bit1 plus, bit0 minus
- pValidArray  in  N_REQ  requester i token valid
- readyArray  out  N_REQ  requester i token accepted this cycle (when pValid)
- dataOutArray_0  out  3  token to shared operator
- validArray_0  out  1  token valid to shared operator
- nReadyArray_0  in  1  shared operator ready
- grant_id  out  clog2(N_REQ)  index of current owner
- busy  out  1  a stream is locked
- digit_idx  out  8  digits transferred in current stream (0 = MSD next)
- overflow  out  1  sticky: a stream was force-released at MAX_DIGITS

## Operation

- States: IDLE, LOCKED.
- IDLE: round-robin pick among pValidArray, searching from rr_ptr upward with wrap. If any set: grant_id <= pick, go LOCKED. Otherwise stay IDLE. No token passes in IDLE.
- LOCKED: dataOutArray_0 = dataInArray[grant_id]; validArray_0 = pValidArray[grant_id]; readyArray[grant_id] = nReadyArray_0, all other ready bits 0.
- Transfer = validArray_0 & nReadyArray_0 in LOCKED.
- Transfer with bit2 = 1: state <= IDLE, rr_ptr <= grant_id+1 (mod N_REQ), digit_idx <= 0.
- Transfer with bit2 = 0 and digit_idx < MAX_DIGITS-1: digit_idx <= digit_idx+1.
- Transfer with bit2 = 0 and digit_idx = MAX_DIGITS-1: forced release, same as the last-token case, and overflow <= 1. Remaining digits of that requester are arbitrated later as a new stream.
- No transfer: all state held. Withdrawing pValid of the owner never releases the grant.
- overflow is cleared only by reset.
- IDLE outputs: dataOutArray_0 = 3'b000, validArray_0 = 0, readyArray = 0.
- busy = (state == LOCKED).

## Timing

- Reset (rstn = 0 at a clk edge) is dominant over everything and applies mid-stream. Values: state IDLE, grant_id 0, rr_ptr 0, digit_idx 0, overflow 0, busy 0, validArray_0 0, readyArray 0, dataOutArray_0 0. A partially sent stream is abandoned; the downstream operator must be reset with it.
- Arbitration latency: request seen in IDLE at cycle t, grant registered at edge t+1, first token visible in cycle t+1.
- LOCKED path is combinational (zero latency) from data/valid to output and from nReady to ready. There are no registers in the token path.
- One-token stream: last flag on the first digit. Lock costs 2 cycles (IDLE + LOCKED).
- Back-to-back streams: exactly one IDLE bubble cycle between the last token of one stream and the first token of the next.
- All requesters continuously valid: grants rotate 0,1,2,3,0,... Fairness bound is N_REQ-1 streams of wait.
- rr_ptr advances only on stream release, never on pick.

## Structure

- Shared package msdf_pkg holds:
  - DIGIT_W = 3, LAST_BIT = 2, PLUS_BIT = 1, MINUS_BIT = 0
  - state enum {IDLE, LOCKED}
  - zero-digit constant 3'b000
- Sub-module: msdf_rr_pick, a combinational round-robin priority picker. Inputs req[N_REQ] and ptr. Outputs any and idx. It is reusable by other shared-operator schedulers.
- Top holds the FSM, grant register, rr_ptr, digit counter, overflow flag and the output mux.

## Test plan

- Reset mid-stream: requester 1 sends 3 of 5 digits, then rstn = 0 for 1 cycle. Required: all outputs at reset values next cycle, grant_id 0, digit_idx 0, overflow 0.
- Single requester: req 2 sends digits (0,1,0),(0,0,1),(1,1,0) with nReady = 1. Required: grant_id 2 one cycle after the request, output tokens identical, digit_idx 0→1→2→0, busy drops after the last token.
- Round-robin: all 4 requesters always valid, each sending 2-digit streams. Required grant order 0,1,2,3,0. Each stream takes 3 cycles (1 IDLE + 2 transfers).
- Backpressure: owner streaming while nReady toggles 1,0,0,1. Required: readyArray[owner] mirrors nReady, digit_idx advances only on the cycles with nReady = 1, and the grant is held throughout.
- Overflow: MAX_DIGITS = 4, requester 0 sends 6 digits with no last flag. Required: forced release after the 4th transfer, overflow = 1 and sticky, requester 0 regranted with digit_idx 0 for the remaining 2 digits.
- Owner pValid drops for 5 cycles while other requesters are valid. Required: no grant change, validArray_0 = 0 during the gap, the stream resumes intact.
